divu_hilo_seq: RTL and testbench

- Multi-cycle sequencer for the unsigned divide (divu, funct 27) and the HI/LO register pair in the pipelined CPU.
- Accepts a divide issued from EX and runs a restoring shift-subtract divider, one quotient bit per cycle.
- Writes HI = remainder and LO = quotient, and serves mfhi/mflo reads.
- Generates a pipeline stall when EX needs HI/LO, or issues a new divide, while a divide is in flight.

---
 rtl/divu_hilo_seq_if.sv | 34 +++
 rtl/divu_hilo_seq.sv | 104 ++++++++++
 tb/tb_divu_hilo_seq.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/divu_hilo_seq_if.sv
// Bundle between the EX stage and the divu/HI-LO sequencer.
//
// Handshake: start/mf_req are presented by EX for the current cycle and are
// consumed only in a cycle where stall is low; while stall is high, EX must
// hold the same request (and operands) until stall drops. done is a one-cycle
// pulse from the sequencer with no back-pressure.
interface divu_hilo_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             mf_req;
  logic             mf_sel;
  logic             flush;
  logic             busy;
  logic             stall;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] mf_data;

  // EX side of the pipeline
  modport master (
    output start, dividend, divisor, mf_req, mf_sel, flush,
    input  busy, stall, done, hi, lo, mf_data
  );

  // Divide sequencer side
  modport slave (
    input  start, dividend, divisor, mf_req, mf_sel, flush,
    output busy, stall, done, hi, lo, mf_data
  );
endinterface

// File: rtl/divu_hilo_seq.sv
// Unsigned restoring divider (one quotient bit per cycle) that owns the
// HI/LO register pair: HI = remainder, LO = quotient. Requests that touch
// HI/LO while a divide is running are stalled in EX until it finishes.
module divu_hilo_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic           clk,
  input  logic           rst_n,
  divu_hilo_seq_if.slave bus,
  output logic           dbg_state_o
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] dvs_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic             done_q;

  logic [WIDTH:0]   rs;
  logic [WIDTH:0]   t;
  logic [WIDTH-1:0] rem_d;
  logic [WIDTH-1:0] quo_d;
  logic             last_step;

  // The partial remainder always stays below the divisor, so WIDTH bits of
  // storage suffice; only the shifted value needs the extra top bit.
  // One restoring shift-subtract step on the current partial remainder.
  always_comb begin
    rs    = {rem_q, quo_q[WIDTH-1]};
    t     = rs - {1'b0, dvs_q};
    rem_d = rs[WIDTH-1:0];
    quo_d = {quo_q[WIDTH-2:0], 1'b0};
    if (!t[WIDTH]) begin
      rem_d = t[WIDTH-1:0];
      quo_d = {quo_q[WIDTH-2:0], 1'b1};
    end
  end

  assign last_step = (cnt_q == CNT_W'(WIDTH - 1));

  // Sequencer FSM: accept a divide, step it, commit HI/LO on the last step.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // A flushed divu never starts.
          if (bus.start && !bus.flush) begin
            dvs_q   <= bus.divisor;
            quo_q   <= bus.dividend;
            rem_q   <= '0;
            cnt_q   <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          if (bus.flush) begin
            // Abort: HI/LO keep their pre-divide values, no done pulse.
            cnt_q   <= '0;
            state_q <= IDLE;
          end else begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            cnt_q <= cnt_q + 1'b1;
            if (last_step) begin
              hi_q    <= rem_d;
              lo_q    <= quo_d;
              done_q  <= 1'b1;
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy    = (state_q == RUN);
  assign bus.stall   = bus.busy & (bus.mf_req | bus.start);
  assign bus.done    = done_q;
  assign bus.hi      = hi_q;
  assign bus.lo      = lo_q;
  assign bus.mf_data = bus.mf_sel ? hi_q : lo_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_divu_hilo_seq.sv
// Directed bench for divu_hilo_seq: expected {hi, lo} pairs are pushed when
// a divide is presented and popped when done pulses.
module tb_divu_hilo_seq;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n;
  logic dbg_state;
  int   checks   = 0;
  int   failures = 0;
  logic [2*W-1:0] exp_q[$];

  divu_hilo_seq_if #(.WIDTH(W)) bus ();

  divu_hilo_seq #(.WIDTH(W), .CNT_W(5)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .dbg_state_o(dbg_state)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "simulation did not finish");
  end

  // Reference: divide by zero gives all-ones quotient and dividend remainder.
  function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
    if (b == '0) return {a, {W{1'b1}}};
    return {a % b, a / b};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Driver: present a divu and record the result it must produce.
  task automatic push_start(input logic [W-1:0] a, input logic [W-1:0] b);
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    exp_q.push_back(model(a, b));
  endtask

  // Scoreboard pop on done.
  task automatic check_result(input string tag);
    logic [2*W-1:0] e;
    checks++;
    assert (exp_q.size() != 0) else begin
      failures++;
      $error("FAIL %s_sb observed=empty expected=entry", tag);
    end
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk({tag, "_hi"}, bus.hi, e[2*W-1:W]);
      chk({tag, "_lo"}, bus.lo, e[W-1:0]);
    end
  endtask

  // Bounded wait for done starting in cycle c0; done must land in cycle lat.
  task automatic wait_done(input string tag, input int c0, input int lat);
    int c;
    c = c0;
    while (bus.done !== 1'b1 && c < lat + 8) begin
      tick();
      settle();
      c++;
    end
    chk({tag, "_latency"}, c, lat);
    if (bus.done === 1'b1) check_result(tag);
  endtask

  initial begin
    int bc;
    int sc;
    int dn;
    logic [W-1:0] ra;
    logic [W-1:0] rb;

    rst_n        = 1'b0;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    bus.mf_req   = 1'b0;
    bus.mf_sel   = 1'b0;
    bus.flush    = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    settle();
    chk("rst_busy", bus.busy, 0);
    chk("rst_stall", bus.stall, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_hi", bus.hi, 0);
    chk("rst_lo", bus.lo, 0);
    chk("rst_state", dbg_state, 0);

    // 100 / 7 with exact busy window
    tick();
    push_start(32'd100, 32'd7);
    settle();
    chk("t1_stall_idle", bus.stall, 0);
    tick();
    bus.start = 1'b0;
    settle();
    bc = 0;
    for (int c = 1; c <= 32; c++) begin
      if (bus.busy === 1'b1 && bus.done === 1'b0) bc++;
      tick();
      settle();
    end
    chk("t1_busy_cycles", bc, 32);
    chk("t1_done", bus.done, 1);
    chk("t1_busy_end", bus.busy, 0);
    check_result("t1");
    tick();
    settle();
    chk("t1_done_drop", bus.done, 0);

    // Divide by zero
    push_start(32'h0000_1234, 32'd0);
    settle();
    tick();
    bus.start = 1'b0;
    settle();
    wait_done("t2", 1, 33);
    tick();

    // mfhi held in EX during a divide
    push_start(32'hFFFF_FFFF, 32'h10);
    settle();
    tick();
    bus.start  = 1'b0;
    bus.mf_req = 1'b1;
    bus.mf_sel = 1'b1;
    settle();
    sc = 0;
    for (int c = 1; c <= 32; c++) begin
      if (bus.stall === 1'b1) sc++;
      tick();
      settle();
    end
    chk("t3_stall_cycles", sc, 32);
    chk("t3_stall_end", bus.stall, 0);
    chk("t3_mfhi", bus.mf_data, 32'h0000_000F);
    chk("t3_done", bus.done, 1);
    check_result("t3");
    bus.mf_sel = 1'b0;
    settle();
    chk("t3_mflo", bus.mf_data, 32'h0FFF_FFFF);
    bus.mf_req = 1'b0;
    tick();

    // Back-to-back: second divu held under stall
    push_start(32'd1000, 32'd33);
    settle();
    tick();
    bus.dividend = 32'd9;
    bus.divisor  = 32'd3;
    settle();
    sc = 0;
    for (int c = 1; c <= 32; c++) begin
      if (bus.stall === 1'b1) sc++;
      tick();
      settle();
    end
    chk("t4_stall_cycles", sc, 32);
    chk("t4_stall_end", bus.stall, 0);
    chk("t4a_done", bus.done, 1);
    check_result("t4a");
    exp_q.push_back(model(32'd9, 32'd3));
    tick();
    bus.start = 1'b0;
    settle();
    chk("t4_second_busy", bus.busy, 1);
    wait_done("t4b", 34, 66);
    tick();

    // Flush mid-divide keeps HI/LO
    push_start(32'd100, 32'd7);
    settle();
    tick();
    bus.start = 1'b0;
    settle();
    wait_done("t5pre", 1, 33);
    tick();
    bus.start    = 1'b1;
    bus.dividend = 32'd50;
    bus.divisor  = 32'd5;
    settle();
    tick();
    bus.start = 1'b0;
    settle();
    for (int c = 1; c < 10; c++) begin
      tick();
    end
    bus.flush  = 1'b1;
    bus.mf_req = 1'b1;
    settle();
    chk("t5_stall_before", bus.stall, 1);
    tick();
    bus.flush = 1'b0;
    settle();
    chk("t5_busy", bus.busy, 0);
    chk("t5_stall", bus.stall, 0);
    chk("t5_hi", bus.hi, 2);
    chk("t5_lo", bus.lo, 14);
    bus.mf_req = 1'b0;
    dn = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      settle();
      if (bus.done !== 1'b0) dn++;
    end
    chk("t5_done_pulses", dn, 0);
    bus.start = 1'b1;
    bus.flush = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.flush = 1'b0;
    settle();
    chk("t5_idle_flush_start", bus.busy, 0);

    // Reset in cycle 5 of a divide
    tick();
    bus.start    = 1'b1;
    bus.dividend = 32'd200;
    bus.divisor  = 32'd9;
    settle();
    tick();
    bus.start = 1'b0;
    for (int c = 1; c < 5; c++) begin
      tick();
    end
    rst_n      = 1'b0;
    bus.mf_req = 1'b1;
    tick();
    rst_n = 1'b1;
    settle();
    chk("t6_busy", bus.busy, 0);
    chk("t6_stall", bus.stall, 0);
    chk("t6_hi", bus.hi, 0);
    chk("t6_lo", bus.lo, 0);
    chk("t6_done", bus.done, 0);
    bus.mf_req = 1'b0;
    tick();
    push_start(32'd12345, 32'd67);
    settle();
    tick();
    bus.start = 1'b0;
    settle();
    wait_done("t6", 1, 33);

    // Random operands
    for (int i = 0; i < 4; i++) begin
      ra = $urandom;
      rb = (i % 2 == 0) ? W'($urandom_range(1, 1000)) : W'($urandom);
      tick();
      push_start(ra, rb);
      settle();
      tick();
      bus.start = 1'b0;
      settle();
      wait_done("rnd", 1, 33);
    end

    chk("sb_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
